yi_result_packer: RTL and testbench

YI_RESULT_PACKER -- requirements
Module: yi_result_packer

---
 rtl/spmv_pkg.sv | 44 ++++
 rtl/axis_beat_reg.sv | 41 ++++
 rtl/yi_result_packer.sv | 191 +++++++++++++++++++
 tb/tb_yi_result_packer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
`default_nettype none
// =============================================================================
// Module  : spmv_pkg
// Brief   : Result-precision encodings, element-width lookup and lane counts.
// Revision: 1.0
// =============================================================================
package spmv_pkg;

    localparam int unsigned c_ELEM_W_MAX = 64;

    typedef enum logic [1:0] {
        MODE_HALF   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_DOUBLE = 2'd2
    } prec_mode_t;

    // Encodings above 2 fall back to double precision.
    function automatic prec_mode_t decode_mode(input logic [2:0] ctrl);
        case (ctrl)
            3'd0:    return MODE_HALF;
            3'd1:    return MODE_SINGLE;
            default: return MODE_DOUBLE;
        endcase
    endfunction

    function automatic int unsigned elem_width(input prec_mode_t mode);
        case (mode)
            MODE_HALF:   return 16;
            MODE_SINGLE: return 32;
            default:     return 64;
        endcase
    endfunction

    function automatic int unsigned lanes_per_beat(input prec_mode_t mode,
                                                   input int unsigned out_width);
        case (mode)
            MODE_HALF:   return out_width / 16;
            MODE_SINGLE: return out_width / 32;
            default:     return out_width / 64;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_beat_reg.sv
`default_nettype none
// =============================================================================
// Module  : axis_beat_reg
// Brief   : Single-entry output register holding one packed beat.
// Revision: 1.0
// =============================================================================
module axis_beat_reg #(
    parameter int DATA_W = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_W-1:0]     i_data,
    input  logic [DATA_W/8-1:0]   i_keep,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_data,
    output logic [DATA_W/8-1:0]   o_keep,
    output logic                  o_last
);

    // The caller only asserts i_load when the register is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_keep  <= i_keep;
            o_last  <= i_last;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/yi_result_packer.sv
`default_nettype none
// =============================================================================
// Module  : yi_result_packer
// Brief   : Packs 16/32/64-bit result elements into wide output beats.
// Revision: 1.0
// =============================================================================
module yi_result_packer
    import spmv_pkg::*;
#(
    parameter int OUT_WIDTH = 256,
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               Ctrl_sig_Yi,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [c_ELEM_W_MAX-1:0]  s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_WIDTH-1:0]     m_data,
    output logic [OUT_WIDTH/8-1:0]   m_keep,
    output logic                     m_last,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     beat_count
);

    localparam int KEEP_W  = OUT_WIDTH / 8;
    localparam int LANE_W  = $clog2(OUT_WIDTH / 16);
    localparam int SHIFT_W = LANE_W + 6;
    localparam int BSH_W   = LANE_W + 3;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [LANE_W-1:0]     r_lane;
    prec_mode_t            r_mode;
    prec_mode_t            w_mode;
    logic [OUT_WIDTH-1:0]  r_asm_data;
    logic [KEEP_W-1:0]     r_asm_keep;
    logic                  r_asm_last;
    logic [CNT_WIDTH-1:0]  r_beat_count;

    logic [63:0]           w_elem;
    logic [7:0]            w_lane_keep;
    logic [SHIFT_W-1:0]    w_bit_shift;
    logic [BSH_W-1:0]      w_byte_shift;
    logic [LANE_W-1:0]     w_last_lane;
    logic [OUT_WIDTH-1:0]  w_beat_data;
    logic [KEEP_W-1:0]     w_beat_keep;
    logic                  w_acc;
    logic                  w_close;
    logic                  w_hs;
    logic                  w_out_free;
    logic                  w_load_out;
    logic                  w_load_held;
    logic [OUT_WIDTH-1:0]  w_out_data;
    logic [KEEP_W-1:0]     w_out_keep;
    logic                  w_out_last;

    // Mode is taken live at lane 0 and frozen for the remaining lanes of the beat.
    always_comb begin
        w_mode       = (r_lane == '0) ? decode_mode(Ctrl_sig_Yi) : r_mode;
        w_elem       = '0;
        w_lane_keep  = '0;
        w_bit_shift  = '0;
        w_byte_shift = '0;
        case (w_mode)
            MODE_HALF: begin
                w_elem       = {48'd0, s_data[15:0]};
                w_lane_keep  = 8'h03;
                w_bit_shift  = SHIFT_W'({r_lane, 4'd0});
                w_byte_shift = BSH_W'({r_lane, 1'b0});
            end
            MODE_SINGLE: begin
                w_elem       = {32'd0, s_data[31:0]};
                w_lane_keep  = 8'h0F;
                w_bit_shift  = SHIFT_W'({r_lane, 5'd0});
                w_byte_shift = BSH_W'({r_lane, 2'd0});
            end
            default: begin
                w_elem       = s_data;
                w_lane_keep  = 8'hFF;
                w_bit_shift  = SHIFT_W'({r_lane, 6'd0});
                w_byte_shift = BSH_W'({r_lane, 3'd0});
            end
        endcase
        w_last_lane = LANE_W'(lanes_per_beat(w_mode, OUT_WIDTH) - 1);
        w_beat_data = r_asm_data | (OUT_WIDTH'(w_elem) << w_bit_shift);
        w_beat_keep = r_asm_keep | (KEEP_W'(w_lane_keep) << w_byte_shift);
    end

    assign w_acc      = s_valid && s_ready;
    assign w_close    = w_acc && (s_last || (r_lane == w_last_lane));
    assign w_hs       = m_valid && m_ready;
    assign w_out_free = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:  if (w_close && !w_out_free) w_state_nxt = ST_STALL;
            ST_STALL: if (w_hs)                   w_state_nxt = ST_FILL;
            default:                              w_state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
        s_ready     = (r_state == ST_FILL) && !rst;
        w_load_held = (r_state == ST_STALL) && w_hs;
        w_load_out  = w_load_held || ((r_state == ST_FILL) && w_close && w_out_free);
        w_out_data  = w_load_held ? r_asm_data : w_beat_data;
        w_out_keep  = w_load_held ? r_asm_keep : w_beat_keep;
        w_out_last  = w_load_held ? r_asm_last : s_last;
    end

    // The assembly register doubles as the hold buffer for a closed beat in STALL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= '0;
            r_mode     <= MODE_HALF;
            r_asm_data <= '0;
            r_asm_keep <= '0;
            r_asm_last <= 1'b0;
        end else if (r_state == ST_FILL) begin
            if (w_acc) begin
                if (r_lane == '0) r_mode <= w_mode;
                if (w_close) begin
                    r_lane <= '0;
                    if (w_out_free) begin
                        r_asm_data <= '0;
                        r_asm_keep <= '0;
                        r_asm_last <= 1'b0;
                    end else begin
                        r_asm_data <= w_beat_data;
                        r_asm_keep <= w_beat_keep;
                        r_asm_last <= s_last;
                    end
                end else begin
                    r_lane     <= r_lane + LANE_W'(1);
                    r_asm_data <= w_beat_data;
                    r_asm_keep <= w_beat_keep;
                    r_asm_last <= 1'b0;
                end
            end
        end else if (w_hs) begin
            r_asm_data <= '0;
            r_asm_keep <= '0;
            r_asm_last <= 1'b0;
        end
    end

    axis_beat_reg #(
        .DATA_W (OUT_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load_out),
        .i_data  (w_out_data),
        .i_keep  (w_out_keep),
        .i_last  (w_out_last),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_keep  (m_keep),
        .o_last  (m_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_count <= '0;
        end else if (w_hs) begin
            r_beat_count <= r_beat_count + CNT_WIDTH'(1);
        end
    end

    assign beat_count = r_beat_count;
    assign busy       = (r_lane != '0) || (r_state == ST_STALL) || m_valid;

endmodule
`default_nettype wire

// File: tb/tb_yi_result_packer.sv
`default_nettype none
// =============================================================================
// Module  : tb_yi_result_packer
// Brief   : Randomised and directed self-checking bench against a beat-queue model.
// Revision: 1.0
// =============================================================================
module tb_yi_result_packer;

    localparam int OW = 256;
    localparam int KW = OW / 8;
    localparam int CW = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     Ctrl_sig_Yi;
    logic           s_valid;
    logic           s_ready;
    logic [63:0]    s_data;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [OW-1:0]  m_data;
    logic [KW-1:0]  m_keep;
    logic           m_last;
    logic           busy;
    logic [CW-1:0]  beat_count;

    always #5 clk = ~clk;

    yi_result_packer #(
        .OUT_WIDTH (OW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Ctrl_sig_Yi (Ctrl_sig_Yi),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_last      (m_last),
        .busy        (busy),
        .beat_count  (beat_count)
    );

    typedef struct {
        logic [OW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [KW-1:0] keep_for(input int nbytes);
        logic [KW:0] t;
        t = ((KW+1)'(1) << nbytes) - (KW+1)'(1);
        return t[KW-1:0];
    endfunction

    // Model: beats queued inside the DUT (output register + held), plus the partial beat.
    beat_t          q[$];
    beat_t          cap[$];
    int             m_lane = 0;
    int             m_ew   = 64;
    logic [OW-1:0]  m_part = '0;
    int unsigned    m_count = 0;
    bit             mdl_acc, mdl_pop, mdl_closed;
    beat_t          mdl_b;
    logic [63:0]    mdl_mask;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_lane  = 0;
            m_part  = '0;
            m_count = 0;
        end else begin
            mdl_acc    = s_valid && (q.size() < 2);
            mdl_pop    = (q.size() > 0) && m_ready;
            mdl_closed = 1'b0;
            if (mdl_acc) begin
                if (m_lane == 0) m_ew = (Ctrl_sig_Yi == 3'd0) ? 16 : (Ctrl_sig_Yi == 3'd1) ? 32 : 64;
                mdl_mask = (m_ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << m_ew) - 64'd1);
                m_part   = m_part | (OW'(s_data & mdl_mask) << (m_ew * m_lane));
                m_lane++;
                if (s_last || (m_lane == OW / m_ew)) begin
                    mdl_b.d    = m_part;
                    mdl_b.k    = keep_for(m_lane * m_ew / 8);
                    mdl_b.l    = s_last;
                    mdl_closed = 1'b1;
                    m_part     = '0;
                    m_lane     = 0;
                end
            end
            if (mdl_pop) begin
                void'(q.pop_front());
                m_count++;
            end
            if (mdl_closed) q.push_back(mdl_b);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("s_ready_in_reset", OW'(s_ready), OW'(0));
        end else begin
            chk("s_ready", OW'(s_ready), OW'(q.size() < 2));
            chk("m_valid", OW'(m_valid), OW'(q.size() > 0));
            chk("busy", OW'(busy), OW'((m_lane != 0) || (q.size() > 0)));
            chk("beat_count", OW'(beat_count), OW'(CW'(m_count)));
            if (q.size() > 0) begin
                chk("m_data", m_data, q[0].d);
                chk("m_keep", OW'(m_keep), OW'(q[0].k));
                chk("m_last", OW'(m_last), OW'(q[0].l));
            end
            if (m_valid && m_ready) cap.push_back('{m_data, m_keep, m_last});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input bit l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                timeout_fail("send");
                break;
            end
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            if (cap.size() >= n) return;
            tick();
        end
        timeout_fail(name);
    endtask

    int idx;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b1; Ctrl_sig_Yi = 3'd2;
        repeat (2) tick();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_s_ready", OW'(s_ready), OW'(1));
        chk("rst_m_valid", OW'(m_valid), OW'(0));
        chk("rst_m_data", m_data, OW'(0));
        chk("rst_m_keep", OW'(m_keep), OW'(0));
        chk("rst_m_last", OW'(m_last), OW'(0));
        chk("rst_busy", OW'(busy), OW'(0));
        chk("rst_beat_count", OW'(beat_count), OW'(0));
        tick();

        // Double precision, four back-to-back elements.
        cap.delete();
        Ctrl_sig_Yi = 3'd2;
        send(64'd1, 1'b0); send(64'd2, 1'b0); send(64'd3, 1'b0);
        chk("s1_no_early_valid", OW'(m_valid), OW'(0));
        send(64'd4, 1'b0);
        @(negedge clk);
        chk("s1_latency", OW'(m_valid), OW'(1));
        wait_beats(1, "s1_wait");
        if (cap.size() >= 1) begin
            chk("s1_data", cap[0].d, {64'd4, 64'd3, 64'd2, 64'd1});
            chk("s1_keep", OW'(cap[0].k), OW'(32'hFFFF_FFFF));
            chk("s1_last", OW'(cap[0].l), OW'(0));
        end

        // Half precision, 16 elements closing on s_last and a full beat at once.
        do_reset();
        cap.delete();
        Ctrl_sig_Yi = 3'd0;
        for (int i = 1; i <= 16; i++) send(64'(i), i == 16);
        wait_beats(1, "s2_wait");
        if (cap.size() >= 1) begin
            chk("s2_data", cap[0].d,
                256'h0010000f000e000d000c000b000a0009_00080007000600050004000300020001);
            chk("s2_keep", OW'(cap[0].k), OW'(32'hFFFF_FFFF));
            chk("s2_last", OW'(cap[0].l), OW'(1));
        end
        chk("s2_beat_count", OW'(beat_count), OW'(1));

        // Single precision, short beat; upper s_data bits must be dropped.
        do_reset();
        cap.delete();
        Ctrl_sig_Yi = 3'd1;
        send(64'hDEAD_BEEF_0000_000A, 1'b0);
        send(64'h1234_5678_0000_000B, 1'b0);
        send(64'hFFFF_FFFF_0000_000C, 1'b1);
        wait_beats(1, "s3_wait");
        if (cap.size() >= 1) begin
            chk("s3_data", cap[0].d, 256'h0000000c_0000000b_0000000a);
            chk("s3_keep", OW'(cap[0].k), OW'(32'h0000_0FFF));
            chk("s3_last", OW'(cap[0].l), OW'(1));
        end

        // Backpressure: two beats buffered, then s_ready must drop.
        do_reset();
        cap.delete();
        Ctrl_sig_Yi = 3'd2;
        m_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            s_valid = (idx < 12);
            s_data  = 64'(100 + idx);
            s_last  = 1'b0;
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            tick();
        end
        chk("s4_accepted_in_stall", OW'(idx), OW'(8));
        chk("s4_s_ready_low", OW'(s_ready), OW'(0));
        m_ready = 1'b1;
        for (int c = 0; c < 60 && idx < 12; c++) begin
            s_valid = 1'b1;
            s_data  = 64'(100 + idx);
            @(negedge clk);
            if (s_ready) idx++;
            tick();
        end
        s_valid = 1'b0;
        wait_beats(3, "s4_wait");
        if (cap.size() >= 3) begin
            chk("s4_beat0", cap[0].d, {64'd103, 64'd102, 64'd101, 64'd100});
            chk("s4_beat2", cap[2].d, {64'd111, 64'd110, 64'd109, 64'd108});
        end

        // Reset mid-beat discards the partial beat.
        do_reset();
        cap.delete();
        Ctrl_sig_Yi = 3'd2;
        send(64'd7, 1'b0); send(64'd8, 1'b0);
        do_reset();
        repeat (3) tick();
        chk("s5_no_emit", OW'(cap.size()), OW'(0));
        for (int i = 9; i <= 12; i++) send(64'(i), 1'b0);
        wait_beats(1, "s5_wait");
        if (cap.size() >= 1) chk("s5_data", cap[0].d, {64'd12, 64'd11, 64'd10, 64'd9});
        chk("s5_beat_count", OW'(beat_count), OW'(1));

        // Mode change mid-beat only takes effect on the next beat.
        do_reset();
        cap.delete();
        Ctrl_sig_Yi = 3'd2;
        send(64'd1, 1'b0); send(64'd2, 1'b0);
        Ctrl_sig_Yi = 3'd0;
        for (int i = 3; i <= 8; i++) send(64'(i), i == 8);
        wait_beats(2, "s6_wait");
        if (cap.size() >= 2) begin
            chk("s6_beat0", cap[0].d, {64'd4, 64'd3, 64'd2, 64'd1});
            chk("s6_beat1", cap[1].d, 256'h0008_0007_0006_0005);
            chk("s6_keep1", OW'(cap[1].k), OW'(32'h0000_00FF));
            chk("s6_last1", OW'(cap[1].l), OW'(1));
        end

        // Random traffic with random backpressure and mode changes.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s_valid     = ($urandom_range(0, 3) != 0);
            s_data      = {$urandom, $urandom};
            s_last      = ($urandom_range(0, 7) == 0);
            Ctrl_sig_Yi = 3'($urandom_range(0, 7));
            m_ready     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        m_ready = 1'b1;
        send({$urandom, $urandom}, 1'b1);
        repeat (10) tick();
        chk("end_busy", OW'(busy), OW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
